// File: rtl/aes_pkg.sv
// Shared AES constants and the byte-packer state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  // PK_FULL is encoded as 1 so the state bit doubles as "block held".
  typedef enum logic {
    PK_FILL = 1'b0,
    PK_FULL = 1'b1
  } pk_state_e;

endpackage

// File: rtl/aes_byte_packer.sv
// Packs a plaintext byte stream into 128-bit AES blocks, MSB-first, with optional PKCS#7 pad on flush.
// Latency: block_valid rises one cycle after the 16th accept or the flush; ct_valid one cycle after handshake.
// Backpressure: in_ready is low while a block is held (FULL) until block_ready takes it.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_byte/in_valid   plaintext byte stream, accepted when in_ready is high
//   in_ready           high while filling a block
//   flush              close the current partial block (ignored when empty or FULL)
//   block_data/_valid  assembled block toward the AES encrypt stage, held until block_ready
//   block_ready        consumer takes the block
//   pad_cnt            number of padding bytes in block_data
//   ct_valid           ciphertext-valid strobe, one cycle after each handshake
//   block_cnt          number of blocks handed off, wraps at 2^32
module aes_byte_packer
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [AES_BLOCK_BITS-1:0] block_data,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic [3:0]                pad_cnt,
  output logic                      ct_valid,
  output logic [31:0]               block_cnt
);

  pk_state_e                 state_q, state_d;
  logic [3:0]                byte_cnt_q, byte_cnt_d;
  logic [AES_BLOCK_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic [3:0]                pad_q, pad_d;
  logic                      ct_q, ct_d;
  logic [31:0]               blk_cnt_q, blk_cnt_d;

  logic       accept;
  logic       handshake;
  logic [4:0] fill_n;    // bytes in the block including this cycle's accept
  logic [4:0] pad_len;
  logic [7:0] pad_byte;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    pad_d      = pad_q;
    blk_cnt_d  = blk_cnt_q;

    accept    = in_valid && (state_q == PK_FILL);
    handshake = valid_q && block_ready;
    fill_n    = {1'b0, byte_cnt_q} + {4'b0, accept};
    pad_len   = 5'd16 - fill_n;
    pad_byte  = PAD_EN ? {3'b000, pad_len} : 8'h00;

    unique case (state_q)
      PK_FILL: begin
        if (accept) begin
          for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (byte_cnt_q == 4'(i)) data_d[AES_BLOCK_BITS-1-8*i -: 8] = in_byte;
          end
          byte_cnt_d = byte_cnt_q + 4'd1;  // wraps to 0 on the 16th byte
        end
        if (fill_n == 5'd16) begin
          // A full block wins over a same-cycle flush: no padding, no extra block.
          state_d = PK_FULL;
          pad_d   = 4'd0;
        end else if (flush && (fill_n != 5'd0)) begin
          // Padding is applied after the same-cycle byte has been inserted.
          for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (5'(i) >= fill_n) data_d[AES_BLOCK_BITS-1-8*i -: 8] = pad_byte;
          end
          pad_d      = pad_len[3:0];
          byte_cnt_d = 4'd0;
          state_d    = PK_FULL;
        end
      end
      PK_FULL: begin
        // Flush is dropped here, not queued.
        if (handshake) begin
          state_d   = PK_FILL;
          blk_cnt_d = blk_cnt_q + 32'd1;
        end
      end
    endcase

    valid_d = (state_d == PK_FULL);
    ct_d    = handshake;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PK_FILL;
      byte_cnt_q <= 4'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pad_q      <= 4'd0;
      ct_q       <= 1'b0;
      blk_cnt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pad_q      <= pad_d;
      ct_q       <= ct_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign in_ready    = (state_q == PK_FILL);
  assign block_data  = data_q;
  assign block_valid = valid_q;
  assign pad_cnt     = pad_q;
  assign ct_valid    = ct_q;
  assign block_cnt   = blk_cnt_q;

endmodule

// File: doc/aes_byte_packer.md
AES_BYTE_PACKER -- requirements
Module: aes_byte_packer

Interface
REQ-001 Parameter PAD_EN, default 1, meaning: 1 = a flush fills the partial block with PKCS#7 padding; 0 = a flush fills it with 8'h00.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_byte  input  8  plaintext byte.
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_ready  output  1  packer accepts a byte this cycle.
REQ-007 flush  input  1  single-cycle request to close the current partial block.
REQ-008 block_data  output  128  assembled plaintext block; feeds the data input of the AES encrypt stage.
REQ-009 block_valid  output  1  block_data holds a complete block.
REQ-010 block_ready  input  1  consumer takes the block this cycle.
REQ-011 pad_cnt  output  4  number of padding bytes in block_data (0..15).
REQ-012 ct_valid  output  1  high exactly one cycle after each block handshake; marks the cycle in which the registered AES ciphertext for that block is valid.
REQ-013 block_cnt  output  32  count of blocks handed off; wraps at 2^32.

Function
REQ-014 States: FILL and FULL, each held in a registered state variable.
REQ-015 in_ready = (state == FILL); a byte is accepted when in_valid && in_ready.
REQ-016 Byte order: the k-th accepted byte of a block (k = 0..15) is written to block_data[127-8k -: 8]; byte 0 is the MSB, per FIPS-197 state ordering.
REQ-017 byte_cnt (4 bits) increments on each accept; on the 16th accept it wraps to 0 and the next state is FULL.
REQ-018 block_valid is registered: it rises the cycle after the 16th accept or after a flush takes effect.
REQ-019 In FULL, block_data, pad_cnt and block_valid hold stable until block_ready is sampled high.
REQ-020 Handshake: on block_valid && block_ready, the next state is FILL, block_valid drops next cycle, and block_cnt increments.
REQ-021 ct_valid is a one-cycle-delayed copy of the handshake pulse, matching the single register stage of the AES encrypt stage.
REQ-022 Flush in FILL with byte_cnt = n > 0: bytes n..15 are filled with value (16-n) when PAD_EN=1, or 8'h00 when PAD_EN=0; pad_cnt = 16-n; next state FULL.
REQ-023 Flush with byte_cnt = 0 and no byte accepted that cycle: ignored, no block produced.
REQ-024 Flush in FULL: ignored, not queued.
REQ-025 Flush in the same cycle as an accept: the byte is stored first, then padding is computed with n = byte_cnt+1.
REQ-026 If that same-cycle byte is the 16th: the block is emitted with pad_cnt = 0 and no extra padding block.
REQ-027 pad_cnt is 0 for every block completed by 16 accepted bytes.
REQ-028 Minimum throughput: 16 accept cycles + 1 FULL cycle per block; no byte is accepted while in FULL.

Reset
REQ-029 On rst assertion, immediately: state = FILL, byte_cnt = 0, block_data = 0, block_valid = 0, pad_cnt = 0, ct_valid = 0, block_cnt = 0.
REQ-030 Reset mid-block or in FULL discards the partial or pending block without emitting it; in_ready = 1 the first cycle after rst deasserts.

Structure
REQ-031 Shared package aes_pkg holds AES_BLOCK_BITS = 128, AES_BLOCK_BYTES = 16 and the packer state encoding.
REQ-032 Single flat module; no sub-module (the datapath is one shift/insert register plus counters).

Verification
REQ-033 Reset, then feed bytes 00,11,22,...,ff, then hold block_ready=1 -> block_data = 128'h00112233445566778899aabbccddeeff, pad_cnt = 0, ct_valid high one cycle after the handshake, block_cnt = 1.
REQ-034 5 bytes 01..05, then flush (PAD_EN=1) -> block_data = 128'h01020304050b0b0b0b0b0b0b0b0b0b0b, pad_cnt = 11.
REQ-035 15 bytes, then flush and the 16th byte 8'hAA in the same cycle -> single block ending in AA, pad_cnt = 0, block_cnt += 1.
REQ-036 Full block with block_ready held 0 for 10 cycles -> block_data stable, in_ready = 0, a flush during the stall has no effect; release -> exactly one handshake.
REQ-037 rst asserted after 7 bytes -> outputs clear immediately, no block emitted; next 16 bytes form a clean block.
REQ-038 Flush with byte_cnt = 0 -> block_valid stays 0; block_cnt unchanged.
